// File: rtl/gwa_payout_ctrl.sv
`timescale 1ns/1ps
// Change-machine credit counter and two-hopper payout sequencer; GWA_TIMEOUT_EN adds idle auto-payout.
// Latency: a coin/key edge acts on the next clock; hopper REQs are state outputs held until ACK.
// Backpressure: coins that overflow MAX_CRED or arrive outside IDLE are returned with a REJ pulse.
module gwa_payout_ctrl #(
  parameter int CW       = 4,
  parameter int MAX_CRED = 9,
  parameter int TIMEOUT  = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EU1,
  input  logic          EU2,
  input  logic          WT,
  input  logic          H2_ACK,
  input  logic          H1_ACK,
  input  logic          H2_EMPTY,
  input  logic          H1_EMPTY,
  output logic          H2_REQ,
  output logic          H1_REQ,
  output logic          REJ1_O,
  output logic          REJ2_O,
  output logic          DONE_O,
  output logic          ERR_O,
  output logic [CW-1:0] CREDIT
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_REQ2, S_REQ1, S_DONE, S_ERR} state_t;

  localparam logic [CW:0] MAX_X = (CW+1)'(MAX_CRED);

  generate
    if (MAX_CRED >= (2 ** CW) || TIMEOUT < 1) begin : g_bad_cfg
      $error("gwa_payout_ctrl: MAX_CRED must fit in CW bits and TIMEOUT must be >= 1");
    end
  endgenerate

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic          rej1_nxt, rej2_nxt;
  logic          eu1_q, eu2_q, wt_q, h2e_q, h1e_q;
  logic          ev_eu1, ev_eu2, ev_wt, ev_h2e, ev_h1e;
  logic [CW:0]   cred_x;
  logic          fit1, fit2, fit3;
  logic          tmo;

  assign ev_eu1 = EU1 & ~eu1_q;
  assign ev_eu2 = EU2 & ~eu2_q;
  assign ev_wt  = WT & ~wt_q;
  assign ev_h2e = H2_EMPTY & ~h2e_q;
  assign ev_h1e = H1_EMPTY & ~h1e_q;

  // One extra bit of headroom so the fit tests cannot wrap.
  assign cred_x = {1'b0, CREDIT};
  assign fit1   = (cred_x + (CW+1)'(1)) <= MAX_X;
  assign fit2   = (cred_x + (CW+1)'(2)) <= MAX_X;
  assign fit3   = (cred_x + (CW+1)'(3)) <= MAX_X;

`ifdef GWA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          ev_coin;

  assign ev_coin = ev_eu1 | ev_eu2;
  assign tmo = (state == S_IDLE) && (CREDIT != '0) && !ev_coin && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (state_nxt != S_IDLE || ev_coin || CREDIT == '0)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    credit_nxt = CREDIT;
    rej1_nxt   = 1'b0;
    rej2_nxt   = 1'b0;
    if (state != S_IDLE) begin
      rej1_nxt = ev_eu1;
      rej2_nxt = ev_eu2;
    end
    case (state)
      S_IDLE: begin
        if (ev_eu1 && ev_eu2) begin
          if (fit3) begin
            credit_nxt = CREDIT + CW'(3);
          end else if (fit2) begin
            credit_nxt = CREDIT + CW'(2);
            rej1_nxt   = 1'b1;
          end else if (fit1) begin
            credit_nxt = CREDIT + CW'(1);
            rej2_nxt   = 1'b1;
          end else begin
            rej1_nxt = 1'b1;
            rej2_nxt = 1'b1;
          end
        end else if (ev_eu2) begin
          if (fit2) credit_nxt = CREDIT + CW'(2);
          else      rej2_nxt   = 1'b1;
        end else if (ev_eu1) begin
          if (fit1) credit_nxt = CREDIT + CW'(1);
          else      rej1_nxt   = 1'b1;
        end
        // The key acts on the credit including any coin taken this cycle.
        if (ev_wt)
          state_nxt = (credit_nxt == '0) ? S_DONE : S_SEL;
        else if (tmo)
          state_nxt = S_SEL;
      end
      S_SEL: begin
        if (CREDIT == '0)
          state_nxt = S_DONE;
        else if (CREDIT >= CW'(2) && !H2_EMPTY)
          state_nxt = S_REQ2;
        else if (!H1_EMPTY)
          state_nxt = S_REQ1;
        else
          state_nxt = S_ERR;
      end
      S_REQ2: begin
        if (H2_ACK) begin
          credit_nxt = CREDIT - CW'(2);
          state_nxt  = S_SEL;
        end else if (ev_h2e) begin
          state_nxt = S_SEL;
        end
      end
      S_REQ1: begin
        if (H1_ACK) begin
          credit_nxt = CREDIT - CW'(1);
          state_nxt  = S_SEL;
        end else if (ev_h1e) begin
          state_nxt = S_SEL;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Edge registers track the inputs even in reset, so levels held across reset are not events.
  always_ff @(posedge clk) begin
    eu1_q <= EU1;
    eu2_q <= EU2;
    wt_q  <= WT;
    h2e_q <= H2_EMPTY;
    h1e_q <= H1_EMPTY;
    if (rst) begin
      state  <= S_IDLE;
      CREDIT <= '0;
      REJ1_O <= 1'b0;
      REJ2_O <= 1'b0;
    end else begin
      state  <= state_nxt;
      CREDIT <= credit_nxt;
      REJ1_O <= rej1_nxt;
      REJ2_O <= rej2_nxt;
    end
  end

  assign H2_REQ = (state == S_REQ2);
  assign H1_REQ = (state == S_REQ1);
  assign DONE_O = (state == S_DONE);
  assign ERR_O  = (state == S_ERR);

endmodule

// File: tb/tb_gwa_payout_ctrl.sv
`timescale 1ns/1ps
// Randomised and directed bench for gwa_payout_ctrl against a cycle-level behavioural model.
module tb_gwa_payout_ctrl;
  localparam int CW = 4, MAX_CRED = 9, TIMEOUT = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, EU1, EU2, WT, H2_ACK, H1_ACK, H2_EMPTY, H1_EMPTY;
  logic H2_REQ, H1_REQ, REJ1_O, REJ2_O, DONE_O, ERR_O;
  logic [CW-1:0] CREDIT;

  gwa_payout_ctrl #(.CW(CW), .MAX_CRED(MAX_CRED), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .EU1(EU1), .EU2(EU2), .WT(WT),
    .H2_ACK(H2_ACK), .H1_ACK(H1_ACK), .H2_EMPTY(H2_EMPTY), .H1_EMPTY(H1_EMPTY),
    .H2_REQ(H2_REQ), .H1_REQ(H1_REQ), .REJ1_O(REJ1_O), .REJ2_O(REJ2_O),
    .DONE_O(DONE_O), .ERR_O(ERR_O), .CREDIT(CREDIT)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: machine phase, credit and registered reject flags.
  localparam int M_IDLE = 0, M_SEL = 1, M_PAY2 = 2, M_PAY1 = 3, M_DONE = 4, M_ERR = 5;
  int m_mode = M_IDLE, m_cred = 0, m_cnt = 0;
  bit m_rej1, m_rej2;
  bit p1, p2, pw, pe2, pe1;
  int acc_val = 0, rej_val = 0, paid_val = 0;

  always @(posedge clk) begin : model_b
    bit e1, e2, ew, ee2, ee1, tmo;
    int acc;
    if (rst) begin
      m_mode = M_IDLE; m_cred = 0; m_cnt = 0; m_rej1 = 0; m_rej2 = 0;
    end else begin
      e1 = EU1 && !p1; e2 = EU2 && !p2; ew = WT && !pw;
      ee2 = H2_EMPTY && !pe2; ee1 = H1_EMPTY && !pe1;
      acc_val += (e1 ? 1 : 0) + (e2 ? 2 : 0);
      m_rej1 = 0; m_rej2 = 0;
      if (m_mode != M_IDLE) begin
        m_rej1 = e1; m_rej2 = e2;
      end
      case (m_mode)
        M_IDLE: begin
          acc = 0;
          if (e1 && e2) begin
            if (m_cred + 3 <= MAX_CRED) acc = 3;
            else if (m_cred + 2 <= MAX_CRED) begin acc = 2; m_rej1 = 1; end
            else if (m_cred + 1 <= MAX_CRED) begin acc = 1; m_rej2 = 1; end
            else begin m_rej1 = 1; m_rej2 = 1; end
          end else if (e2) begin
            if (m_cred + 2 <= MAX_CRED) acc = 2; else m_rej2 = 1;
          end else if (e1) begin
            if (m_cred + 1 <= MAX_CRED) acc = 1; else m_rej1 = 1;
          end
          tmo = 0;
`ifdef GWA_TIMEOUT_EN
          tmo = (m_cred > 0) && !(e1 || e2) && (m_cnt == TIMEOUT - 1);
          if (e1 || e2 || m_cred == 0) m_cnt = 0; else m_cnt++;
`endif
          m_cred += acc;
          if (ew) m_mode = (m_cred == 0) ? M_DONE : M_SEL;
          else if (tmo) m_mode = M_SEL;
          if (m_mode != M_IDLE) m_cnt = 0;
        end
        M_SEL: begin
          if (m_cred == 0) m_mode = M_DONE;
          else if (m_cred >= 2 && !H2_EMPTY) m_mode = M_PAY2;
          else if (m_cred >= 1 && !H1_EMPTY) m_mode = M_PAY1;
          else m_mode = M_ERR;
        end
        M_PAY2: begin
          if (H2_ACK) begin m_cred -= 2; m_mode = M_SEL; end
          else if (ee2) m_mode = M_SEL;
        end
        M_PAY1: begin
          if (H1_ACK) begin m_cred -= 1; m_mode = M_SEL; end
          else if (ee1) m_mode = M_SEL;
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_ERR;
      endcase
    end
    p1 = EU1; p2 = EU2; pw = WT; pe2 = H2_EMPTY; pe1 = H1_EMPTY;
  end

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("credit", CREDIT, m_cred);
      chk("h2_req", H2_REQ, m_mode == M_PAY2);
      chk("h1_req", H1_REQ, m_mode == M_PAY1);
      chk("rej1", REJ1_O, m_rej1);
      chk("rej2", REJ2_O, m_rej2);
      chk("done", DONE_O, m_mode == M_DONE);
      chk("err", ERR_O, m_mode == M_ERR);
    end
    if (rst === 1'b0) rej_val += REJ1_O + 2 * REJ2_O;
  end

  // Hopper responder: acknowledges after dly cycles of REQ, optional stray acks.
  int dly = 2;
  bit spur = 0;
  int n_ack2 = 0, n_ack1 = 0, n_req2 = 0;
  initial begin
    int w2, w1;
    w2 = 0; w1 = 0; H2_ACK = 0; H1_ACK = 0;
    forever begin
      @(negedge clk);
      H2_ACK = 0; H1_ACK = 0;
      if (H2_REQ && !rst) begin
        w2++; n_req2++;
        if (w2 >= dly) begin H2_ACK = 1; w2 = 0; n_ack2++; paid_val += 2; end
      end else begin
        w2 = 0;
        if (spur && $urandom_range(15) == 0) H2_ACK = 1;
      end
      if (H1_REQ && !rst) begin
        w1++;
        if (w1 >= dly) begin H1_ACK = 1; w1 = 0; n_ack1++; paid_val += 1; end
      end else begin
        w1 = 0;
        if (spur && $urandom_range(15) == 0) H1_ACK = 1;
      end
    end
  end

  int a0, r0, pd0;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; EU1 = 0; EU2 = 0; WT = 0;
    tick(2);
    rst = 0;
    a0 = acc_val; r0 = rej_val; pd0 = paid_val;
    tick(1);
  endtask

  task automatic pulse(input bit a, input bit b, input bit w);
    EU1 = a; EU2 = b; WT = w;
    tick(1);
    EU1 = 0; EU2 = 0; WT = 0;
    tick(1);
  endtask

  task automatic wait_sig(input string name, input int which, input int limit, output int cyc);
    bit s, found;
    found = 0; cyc = 0;
    while (!found && cyc < limit) begin
      case (which)
        0: s = DONE_O;
        1: s = ERR_O;
        2: s = H2_REQ;
        default: s = H1_REQ;
      endcase
      if (s) found = 1;
      else begin tick(1); cyc++; end
    end
    chk(name, found, 1);
  endtask

  // Value in = value rejected + value paid + credit left, once no handshake is in flight.
  task automatic conserve(input string name);
    int low;
    EU1 = 0; EU2 = 0; WT = 0; low = 0;
    for (int i = 0; i < 400 && low < 3; i++) begin
      tick(1);
      low = (H2_REQ || H1_REQ) ? 0 : low + 1;
    end
    chk({name, "_quiet"}, low >= 3, 1);
    chk(name, (acc_val - a0) - (rej_val - r0) - (paid_val - pd0), CREDIT);
  endtask

  initial begin
    int cyc, b1, b2, br2;
    rst = 1; EU1 = 0; EU2 = 1; WT = 0; H2_EMPTY = 0; H1_EMPTY = 0;
    tick(3);
    chk_en = 1;
    chk("rst_credit", CREDIT, 0);
    chk("rst_outs", {H2_REQ, H1_REQ, REJ1_O, REJ2_O, DONE_O, ERR_O}, 0);
    rst = 0;
    tick(3);
    chk("level_at_reset", CREDIT, 0);
    EU2 = 0;
    do_reset();

    // 1: coins 1 then 2, payout via both hoppers
    pulse(1, 0, 0); chk("t1_c1", CREDIT, 1);
    pulse(0, 1, 0); chk("t1_c3", CREDIT, 3);
    b1 = n_ack1; b2 = n_ack2;
    WT = 1; tick(1); WT = 0;
    wait_sig("t1_done", 0, 60, cyc);
    chk("t1_ack2", n_ack2 - b2, 1);
    chk("t1_ack1", n_ack1 - b1, 1);
    chk("t1_c0", CREDIT, 0);
    conserve("t1_sum");

    // 2: overflow handling at MAX_CRED
    do_reset();
    repeat (4) pulse(0, 1, 0);
    chk("t2_c8", CREDIT, 8);
    EU1 = 1; EU2 = 1; tick(1);
    chk("t2_c9", CREDIT, 9);
    chk("t2_rej2", REJ2_O, 1);
    chk("t2_no_rej1", REJ1_O, 0);
    EU1 = 0; EU2 = 0; tick(1);
    chk("t2_rej2_1cyc", REJ2_O, 0);
    EU1 = 1; tick(1);
    chk("t2_rej1", REJ1_O, 1);
    chk("t2_c9_held", CREDIT, 9);
    EU1 = 0; tick(1);
    conserve("t2_sum");

    // 3: 2-unit hopper empty, four 1-unit coins
    do_reset();
    pulse(0, 1, 0); pulse(0, 1, 0);
    H2_EMPTY = 1;
    b1 = n_ack1; br2 = n_req2;
    WT = 1; tick(1); WT = 0;
    wait_sig("t3_done", 0, 100, cyc);
    chk("t3_ack1", n_ack1 - b1, 4);
    chk("t3_no_h2req", n_req2 - br2, 0);
    chk("t3_c0", CREDIT, 0);
    conserve("t3_sum");
    H2_EMPTY = 0;

    // 4: 1-unit hopper empty leaves 1 unit stuck -> ERR until reset
    do_reset();
    pulse(1, 0, 0); pulse(0, 1, 0);
    H1_EMPTY = 1;
    b2 = n_ack2;
    WT = 1; tick(1); WT = 0;
    wait_sig("t4_err", 1, 60, cyc);
    chk("t4_c1", CREDIT, 1);
    chk("t4_ack2", n_ack2 - b2, 1);
    tick(5);
    chk("t4_err_sticky", ERR_O, 1);
    conserve("t4_sum");
    H1_EMPTY = 0;
    do_reset();
    chk("t4_err_cleared", ERR_O, 0);

    // 5: key with zero credit; held coin level counts once
    WT = 1; tick(1);
    chk("t5_done", DONE_O, 1);
    WT = 0; tick(1);
    chk("t5_done_1cyc", DONE_O, 0);
    EU2 = 1; tick(10); EU2 = 0; tick(1);
    chk("t5_held_once", CREDIT, 2);

    // 6: reset mid-handshake
    do_reset();
    pulse(0, 1, 0);
    b2 = n_ack2;
    WT = 1; tick(1); WT = 0;
    wait_sig("t6_req", 2, 20, cyc);
    rst = 1; tick(1);
    chk("t6_req_drop", H2_REQ, 0);
    chk("t6_c0", CREDIT, 0);
    chk("t6_no_ack", n_ack2 - b2, 0);
    rst = 0; tick(1);

    do_reset();
    EU1 = 1; tick(1); EU1 = 0;
`ifdef GWA_TIMEOUT_EN
    wait_sig("tmo_req", 3, 60, cyc);
    chk("tmo_start", cyc, TIMEOUT + 1);
    wait_sig("tmo_done", 0, 20, cyc);
`else
    tick(3 * TIMEOUT);
    chk("no_tmo_credit", CREDIT, 1);
`endif
    conserve("tmo_sum");

    // Random episodes
    spur = 1;
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      dly = $urandom_range(1, 4);
      H2_EMPTY = ($urandom_range(3) == 0);
      H1_EMPTY = ($urandom_range(3) == 0);
      for (int c = 0; c < 150; c++) begin
        EU1 = ($urandom_range(3) == 0);
        EU2 = ($urandom_range(4) == 0);
        WT  = ($urandom_range(9) == 0);
        if ($urandom_range(19) == 0) H2_EMPTY = ~H2_EMPTY;
        if ($urandom_range(19) == 0) H1_EMPTY = ~H1_EMPTY;
        tick(1);
      end
      conserve("rand_sum");
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
